uart_cmd_framer: RTL and testbench



---
 rtl/uart_frm_pkg.sv | 12 +
 rtl/UART.sv | 129 ++++++++++++
 rtl/uart_cmd_framer.sv | 196 +++++++++++++++++++
 tb/tb_uart_cmd_framer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frm_pkg.sv
// Shared state encodings and counter-width helper for the UART command framer.
package uart_frm_pkg;

  typedef enum logic {RX_IDLE, RX_COLLECT} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_WAIT} tx_state_t;

  // Bits needed to hold 0..n, never less than one.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/UART.sv
// 8N1 UART transceiver: oversampling-free receiver with mid-bit sampling, plain transmitter.
module UART #(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic       TX,
  output logic       rx_rdy,
  input  logic       clr_rx_rdy,
  output logic [7:0] rx_data,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done
);
  localparam int BW = $clog2(BAUD_DIV + 1);

  logic [1:0]    rx_sync_q;
  logic          rx_in;
  logic          rx_busy_q, rx_busy_d;
  logic [BW-1:0] rx_baud_q, rx_baud_d;
  logic [3:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          rx_rdy_q, rx_rdy_d;
  logic [7:0]    rx_data_q, rx_data_d;

  logic          tx_busy_q, tx_busy_d;
  logic [BW-1:0] tx_baud_q, tx_baud_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [9:0]    tx_sh_q, tx_sh_d;
  logic          tx_done_q, tx_done_d;

  assign rx_in   = rx_sync_q[1];
  assign rx_rdy  = rx_rdy_q;
  assign rx_data = rx_data_q;
  assign tx_done = tx_done_q;
  assign TX      = tx_busy_q ? tx_sh_q[0] : 1'b1;

  always_comb begin
    rx_busy_d = rx_busy_q;
    rx_baud_d = rx_baud_q;
    rx_bit_d  = rx_bit_q;
    rx_sh_d   = rx_sh_q;
    rx_rdy_d  = rx_rdy_q;
    rx_data_d = rx_data_q;
    if (clr_rx_rdy) rx_rdy_d = 1'b0;
    if (!rx_busy_q) begin
      if (!rx_in) begin
        rx_busy_d = 1'b1;
        rx_baud_d = BW'(BAUD_DIV / 2);
        rx_bit_d  = '0;
      end
    end else if (rx_baud_q != '0) begin
      rx_baud_d = rx_baud_q - 1'b1;
    end else begin
      rx_baud_d = BW'(BAUD_DIV - 1);
      rx_bit_d  = rx_bit_q + 1'b1;
      // Bit 0 is the start bit: a high sample there was a glitch.
      if (rx_bit_q == 4'd0) begin
        if (rx_in) rx_busy_d = 1'b0;
      end else if (rx_bit_q == 4'd9) begin
        rx_busy_d = 1'b0;
        if (rx_in) begin
          rx_rdy_d  = 1'b1;
          rx_data_d = rx_sh_q;
        end
      end else begin
        rx_sh_d = {rx_in, rx_sh_q[7:1]};
      end
    end
  end

  always_comb begin
    tx_busy_d = tx_busy_q;
    tx_baud_d = tx_baud_q;
    tx_bit_d  = tx_bit_q;
    tx_sh_d   = tx_sh_q;
    tx_done_d = tx_done_q;
    if (trmt) begin
      tx_busy_d = 1'b1;
      tx_sh_d   = {1'b1, tx_data, 1'b0};
      tx_baud_d = BW'(BAUD_DIV - 1);
      tx_bit_d  = '0;
      tx_done_d = 1'b0;
    end else if (tx_busy_q) begin
      if (tx_baud_q != '0) begin
        tx_baud_d = tx_baud_q - 1'b1;
      end else if (tx_bit_q == 4'd9) begin
        tx_busy_d = 1'b0;
        tx_done_d = 1'b1;
      end else begin
        tx_sh_d   = {1'b1, tx_sh_q[9:1]};
        tx_bit_d  = tx_bit_q + 1'b1;
        tx_baud_d = BW'(BAUD_DIV - 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync_q <= 2'b11;
      rx_busy_q <= 1'b0;
      rx_baud_q <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
      rx_rdy_q  <= 1'b0;
      rx_data_q <= '0;
      tx_busy_q <= 1'b0;
      tx_baud_q <= '0;
      tx_bit_q  <= '0;
      tx_sh_q   <= '1;
      tx_done_q <= 1'b0;
    end else begin
      rx_sync_q <= {rx_sync_q[0], RX};
      rx_busy_q <= rx_busy_d;
      rx_baud_q <= rx_baud_d;
      rx_bit_q  <= rx_bit_d;
      rx_sh_q   <= rx_sh_d;
      rx_rdy_q  <= rx_rdy_d;
      rx_data_q <= rx_data_d;
      tx_busy_q <= tx_busy_d;
      tx_baud_q <= tx_baud_d;
      tx_bit_q  <= tx_bit_d;
      tx_sh_q   <= tx_sh_d;
      tx_done_q <= tx_done_d;
    end
  end

endmodule

// File: rtl/uart_cmd_framer.sv
// Frames CMD_BYTES received UART bytes into a command word with timeout/overrun
// handling, and serialises a RESP_BYTES response MSB first.
module uart_cmd_framer
  import uart_frm_pkg::*;
#(
  parameter int CMD_BYTES   = 2,
  parameter int RESP_BYTES  = 1,
  parameter int TIMEOUT_CYC = 1_000_000,
  parameter int BAUD_DIV    = 434
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    RX,
  output logic                    TX,
  output logic [8*CMD_BYTES-1:0]  cmd,
  output logic                    cmd_rdy,
  input  logic                    clr_cmd_rdy,
  output logic                    overrun,
  output logic                    frame_to,
  input  logic [8*RESP_BYTES-1:0] resp,
  input  logic                    trmt,
  output logic                    tx_busy,
  output logic                    resp_done
);
  localparam int CW  = 8 * CMD_BYTES;
  localparam int RW  = 8 * RESP_BYTES;
  localparam int BCW = cnt_width(CMD_BYTES);
  localparam int RCW = cnt_width(RESP_BYTES);
  localparam int TCW = cnt_width(TIMEOUT_CYC);

  logic       rx_rdy, clr_rx_rdy, u_trmt, tx_done;
  logic [7:0] rx_data, tx_data;

  UART #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk        (clk),
    .rst_n      (!rst),
    .RX         (RX),
    .TX         (TX),
    .rx_rdy     (rx_rdy),
    .clr_rx_rdy (clr_rx_rdy),
    .rx_data    (rx_data),
    .trmt       (u_trmt),
    .tx_data    (tx_data),
    .tx_done    (tx_done)
  );

  rx_state_t      rx_state_q, rx_state_d;
  logic [CW-1:0]  shift_q, shift_d, shift_in, cmd_q, cmd_d;
  logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
  logic [TCW-1:0] to_cnt_q, to_cnt_d;
  logic           cmd_rdy_q, cmd_rdy_d, overrun_q, overrun_d, frame_to_q, frame_to_d;
  logic           frame_done, to_hit;

  generate
    if (CMD_BYTES == 1) begin : g_one_byte
      assign shift_in = rx_data;
    end else begin : g_multi_byte
      assign shift_in = {shift_q[CW-9:0], rx_data};
    end
  endgenerate

  assign clr_rx_rdy = rx_rdy;
  assign to_hit     = (TIMEOUT_CYC != 0) && (to_cnt_q == TCW'(TIMEOUT_CYC));

  always_comb begin
    rx_state_d = rx_state_q;
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    to_cnt_d   = to_cnt_q;
    frame_done = 1'b0;
    frame_to_d = 1'b0;
    if (rx_rdy) begin
      shift_d  = shift_in;
      to_cnt_d = '0;
      if (rx_state_q == RX_IDLE) begin
        if (CMD_BYTES == 1) begin
          frame_done = 1'b1;
          byte_cnt_d = '0;
        end else begin
          rx_state_d = RX_COLLECT;
          byte_cnt_d = BCW'(1);
        end
      end else if (byte_cnt_q == BCW'(CMD_BYTES - 1)) begin
        frame_done = 1'b1;
        byte_cnt_d = '0;
        rx_state_d = RX_IDLE;
      end else begin
        byte_cnt_d = byte_cnt_q + 1'b1;
      end
    end else if (rx_state_q == RX_COLLECT) begin
      // Stale bytes left in shift_q are pushed out by the next full frame.
      if (to_hit) begin
        frame_to_d = 1'b1;
        byte_cnt_d = '0;
        to_cnt_d   = '0;
        rx_state_d = RX_IDLE;
      end else if (TIMEOUT_CYC != 0) begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    cmd_d     = cmd_q;
    cmd_rdy_d = cmd_rdy_q;
    overrun_d = overrun_q;
    if (clr_cmd_rdy) begin
      cmd_rdy_d = 1'b0;
      overrun_d = 1'b0;
    end
    // A completing frame wins over a simultaneous acknowledge.
    if (frame_done) begin
      cmd_d     = shift_in;
      cmd_rdy_d = 1'b1;
      if (cmd_rdy_q && !clr_cmd_rdy) overrun_d = 1'b1;
    end
  end

  tx_state_t      tx_state_q, tx_state_d;
  logic [RW-1:0]  resp_sh_q, resp_sh_d;
  logic [RCW-1:0] resp_cnt_q, resp_cnt_d;
  logic           resp_done_q, resp_done_d;

  always_comb begin
    tx_state_d  = tx_state_q;
    resp_sh_d   = resp_sh_q;
    resp_cnt_d  = resp_cnt_q;
    resp_done_d = 1'b0;
    u_trmt      = 1'b0;
    tx_data     = resp_sh_q[RW-1 -: 8];
    case (tx_state_q)
      TX_IDLE: begin
        if (trmt) begin
          resp_sh_d  = resp;
          resp_cnt_d = '0;
          tx_state_d = TX_SEND;
        end
      end
      TX_SEND: begin
        u_trmt     = 1'b1;
        tx_state_d = TX_WAIT;
      end
      TX_WAIT: begin
        if (tx_done) begin
          if (resp_cnt_q == RCW'(RESP_BYTES - 1)) begin
            resp_done_d = 1'b1;
            tx_state_d  = TX_IDLE;
          end else begin
            resp_sh_d  = resp_sh_q << 8;
            resp_cnt_d = resp_cnt_q + 1'b1;
            tx_state_d = TX_SEND;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q  <= RX_IDLE;
      shift_q     <= '0;
      byte_cnt_q  <= '0;
      to_cnt_q    <= '0;
      cmd_q       <= '0;
      cmd_rdy_q   <= 1'b0;
      overrun_q   <= 1'b0;
      frame_to_q  <= 1'b0;
      tx_state_q  <= TX_IDLE;
      resp_sh_q   <= '0;
      resp_cnt_q  <= '0;
      resp_done_q <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      shift_q     <= shift_d;
      byte_cnt_q  <= byte_cnt_d;
      to_cnt_q    <= to_cnt_d;
      cmd_q       <= cmd_d;
      cmd_rdy_q   <= cmd_rdy_d;
      overrun_q   <= overrun_d;
      frame_to_q  <= frame_to_d;
      tx_state_q  <= tx_state_d;
      resp_sh_q   <= resp_sh_d;
      resp_cnt_q  <= resp_cnt_d;
      resp_done_q <= resp_done_d;
    end
  end

  assign cmd       = cmd_q;
  assign cmd_rdy   = cmd_rdy_q;
  assign overrun   = overrun_q;
  assign frame_to  = frame_to_q;
  assign resp_done = resp_done_q;
  assign tx_busy   = (tx_state_q != TX_IDLE) || resp_done_q;

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Scoreboard bench: stimulus queues expected commands, timeouts and TX bytes; monitors pop and compare.
module tb_uart_cmd_framer;
  localparam int CB = 3;
  localparam int RB = 2;
  localparam int TO = 600;
  localparam int BD = 8;
  localparam int LONG_GAP  = 800;
  localparam int SHORT_MAX = 100;

  logic            clk = 1'b0;
  logic            rst;
  logic            rx_line;
  logic            TX;
  logic [8*CB-1:0] cmd;
  logic            cmd_rdy;
  logic            clr_cmd_rdy;
  logic            overrun;
  logic            frame_to;
  logic [8*RB-1:0] resp;
  logic            trmt;
  logic            tx_busy;
  logic            resp_done;

  always #5 clk = ~clk;

  uart_cmd_framer #(.CMD_BYTES(CB), .RESP_BYTES(RB), .TIMEOUT_CYC(TO), .BAUD_DIV(BD)) dut (
    .clk(clk), .rst(rst), .RX(rx_line), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .overrun(overrun), .frame_to(frame_to), .resp(resp),
    .trmt(trmt), .tx_busy(tx_busy), .resp_done(resp_done)
  );

  int tests = 0;
  int fails = 0;
  int exp_to = 0;
  int exp_done = 0;
  bit auto_ack = 1'b1;
  logic [63:0] exp_cmd[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  partial[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, req);
    end else begin
      $display("[TB] pass %s: 0x%0h", nm, act);
    end
  endtask

  task automatic check_reset(input string nm);
    check({nm, "_cmd"}, 64'(cmd), 64'd0);
    check({nm, "_cmd_rdy"}, 64'(cmd_rdy), 64'd0);
    check({nm, "_overrun"}, 64'(overrun), 64'd0);
    check({nm, "_frame_to"}, 64'(frame_to), 64'd0);
    check({nm, "_tx_busy"}, 64'(tx_busy), 64'd0);
    check({nm, "_resp_done"}, 64'(resp_done), 64'd0);
    check({nm, "_TX"}, 64'(TX), 64'd1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_line = f[i];
      repeat (BD) @(negedge clk);
    end
  endtask

  function automatic logic [63:0] pack_partial();
    logic [63:0] v = 64'd0;
    for (int i = 0; i < partial.size(); i++) v = (v << 8) | 64'(partial[i]);
    return v;
  endfunction

  // Model: a long idle before a byte discards any partial frame; CB bytes make a command.
  task automatic send_model(input logic [7:0] b, input bit long_gap);
    if (long_gap) begin
      if (partial.size() > 0) begin
        exp_to++;
        partial.delete();
      end
      repeat (LONG_GAP) @(negedge clk);
    end else begin
      repeat ($urandom_range(0, SHORT_MAX)) @(negedge clk);
    end
    partial.push_back(b);
    if (partial.size() == CB) begin
      if (auto_ack) exp_cmd.push_back(pack_partial());
      partial.delete();
    end
    send_byte(b);
  endtask

  task automatic wait_tx_idle(input string nm);
    int n = 0;
    while (tx_busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(nm, 64'(tx_busy), 64'd0);
  endtask

  task automatic start_resp(input logic [8*RB-1:0] r, input bit expect_it);
    resp = r;
    trmt = 1'b1;
    if (expect_it) begin
      for (int i = RB - 1; i >= 0; i--) exp_tx.push_back(8'((r >> (8 * i)) & 8'hFF));
      exp_done++;
    end
    @(negedge clk);
    trmt = 1'b0;
  endtask

  task automatic mon_cmd();
    forever begin
      @(negedge clk);
      if (cmd_rdy && auto_ack) begin
        if (exp_cmd.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL cmd_unexpected: got 0x%0h, none required", cmd);
        end else begin
          check("cmd", 64'(cmd), exp_cmd.pop_front());
          check("cmd_overrun", 64'(overrun), 64'd0);
        end
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
      end
    end
  endtask

  task automatic mon_to();
    forever begin
      @(negedge clk);
      if (frame_to) begin
        tests++;
        if (exp_to == 0) begin
          fails++;
          $display("FAIL frame_to_unexpected: got pulse, required none");
        end else begin
          exp_to--;
          $display("[TB] pass frame_to pulse");
        end
      end
    end
  endtask

  task automatic mon_done();
    forever begin
      @(negedge clk);
      if (resp_done) begin
        tests++;
        if (exp_done == 0) begin
          fails++;
          $display("FAIL resp_done_unexpected: got pulse, required none");
        end else begin
          exp_done--;
          $display("[TB] pass resp_done pulse");
        end
        check("busy_at_done", 64'(tx_busy), 64'd1);
      end
    end
  endtask

  task automatic mon_tx();
    logic [7:0] b;
    logic ab, stop;
    forever begin
      @(negedge clk);
      if (!rst && TX == 1'b0) begin
        ab = 1'b0;
        b = 8'h00;
        for (int c = 0; c < BD / 2; c++) begin @(negedge clk); ab = ab | rst; end
        for (int k = 0; k < 8; k++) begin
          for (int c = 0; c < BD; c++) begin @(negedge clk); ab = ab | rst; end
          b[k] = TX;
        end
        for (int c = 0; c < BD; c++) begin @(negedge clk); ab = ab | rst; end
        stop = TX;
        if (!ab) begin
          if (exp_tx.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL tx_unexpected: got byte 0x%0h, none required", b);
          end else begin
            check("tx_byte", 64'(b), 64'(exp_tx.pop_front()));
            check("tx_stop", 64'(stop), 64'd1);
          end
        end
      end
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] u;
    rst = 1'b1;
    rx_line = 1'b1;
    trmt = 1'b0;
    resp = '0;
    clr_cmd_rdy = 1'b0;
    fork
      mon_cmd();
      mon_to();
      mon_done();
      mon_tx();
    join_none
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Plain frame, then a frame preceded by a timed-out partial byte.
    send_model(8'h12, 1'b0); send_model(8'h34, 1'b0); send_model(8'h56, 1'b0);
    send_model(8'hAB, 1'b0);
    send_model(8'hCD, 1'b1); send_model(8'hEF, 1'b0); send_model(8'h01, 1'b0);
    repeat (10) @(negedge clk);

    // Two-byte response with a second trmt arriving mid-transmission.
    start_resp(16'hBEEF, 1'b1);
    check("tx_busy_start", 64'(tx_busy), 64'd1);
    repeat (20) @(negedge clk);
    start_resp(16'h1234, 1'b0);
    wait_tx_idle("tx_idle_beef");
    repeat (20) @(negedge clk);

    // Overrun: two frames with no acknowledge.
    auto_ack = 1'b0;
    send_model(8'h11, 1'b0); send_model(8'h11, 1'b0); send_model(8'h11, 1'b0);
    send_model(8'h22, 1'b0); send_model(8'h22, 1'b0); send_model(8'h22, 1'b0);
    repeat (4) @(negedge clk);
    check("ovr_cmd", 64'(cmd), 64'h222222);
    check("ovr_cmd_rdy", 64'(cmd_rdy), 64'd1);
    check("ovr_overrun", 64'(overrun), 64'd1);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    @(negedge clk);
    check("ovr_clr_cmd_rdy", 64'(cmd_rdy), 64'd0);
    check("ovr_clr_overrun", 64'(overrun), 64'd0);

    // Acknowledge landing in the same cycle as a completion while cmd_rdy is set.
    send_model(8'h33, 1'b0); send_model(8'h33, 1'b0); send_model(8'h33, 1'b0);
    repeat (4) @(negedge clk);
    check("same_pre_cmd_rdy", 64'(cmd_rdy), 64'd1);
    fork
      begin
        send_model(8'h44, 1'b0); send_model(8'h44, 1'b0); send_model(8'h44, 1'b0);
      end
      begin
        int seen = 0;
        int n = 0;
        while (seen < 3 && n < 3000) begin
          @(negedge clk);
          n++;
          if (dut.rx_rdy) seen++;
        end
        check("same_bytes_seen", 64'(seen), 64'd3);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        check("same_cmd_rdy", 64'(cmd_rdy), 64'd1);
        check("same_overrun", 64'(overrun), 64'd0);
        check("same_cmd", 64'(cmd), 64'h444444);
      end
    join
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    @(negedge clk);
    check("same_clr_cmd_rdy", 64'(cmd_rdy), 64'd0);
    auto_ack = 1'b1;

    // Reset mid-command, then a clean frame.
    send_model(8'h55, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    partial.delete();
    @(negedge clk);
    check_reset("rst_mid_cmd");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send_model(8'h9A, 1'b0); send_model(8'hBC, 1'b0); send_model(8'hDE, 1'b0);
    repeat (10) @(negedge clk);

    // Reset mid-response: no bytes or resp_done may be reported for it.
    start_resp(16'hA5C3, 1'b0);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset("rst_mid_resp");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);

    // Random full-duplex traffic.
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          u = $urandom;
          send_model(u[7:0], $urandom_range(0, 9) == 0);
        end
      end
      begin
        for (int i = 0; i < 4; i++) begin
          repeat ($urandom_range(5, 300)) @(negedge clk);
          u = $urandom;
          start_resp(u[8*RB-1:0], 1'b1);
          wait_tx_idle("tx_idle_rand");
        end
      end
    join
    if (partial.size() > 0) begin
      exp_to++;
      partial.delete();
    end
    repeat (1000) @(negedge clk);

    check("left_cmd", 64'(exp_cmd.size()), 64'd0);
    check("left_tx", 64'(exp_tx.size()), 64'd0);
    check("left_done", 64'(exp_done), 64'd0);
    check("left_to", 64'(exp_to), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
